// File: rtl/cpu_pkg.sv
// Shared types for the instruction-fetch path: reset vector, epoch width and the buffered fetch entry.
package cpu_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'hFFFF_0000;
    localparam int          EPOCH_W            = 9;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Synchronous FIFO of fetch entries; push visible one cycle later (no bypass).
// Flush dominates push/pop; caller guarantees no push when full and no pop when empty.
module cpu_ifetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_dat,
    input  logic                     i_pop,
    output fetch_entry_t             o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/cpu_ifetch.sv
// Fetch initiator: sequential PCs, epoch-tagged pipelined icache requests, buffered hand-off to decode.
// Latency 2 cycles request-to-decode at 1-cycle icache; issue throttled by credits so responses never overflow.
module cpu_ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               cpu_icache_request,
    output logic [31:0]        cpu_icache_addr,
    output logic [EPOCH_W-1:0] cpu_icache_tag,
    input  logic               cpu_icache_ready,
    input  logic               cpu_icache_rvalid,
    input  logic [31:0]        cpu_icache_rdata,
    input  logic [31:0]        cpu_icache_raddr,
    input  logic [EPOCH_W-1:0] cpu_icache_rtag,
    input  logic               jump_taken,
    input  logic [31:0]        jump_target,
    output logic               ifetch_valid,
    output logic [31:0]        ifetch_instr,
    output logic [31:0]        ifetch_pc,
    input  logic               decode_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        r_fetch_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic [CW-1:0]      r_inflight;

    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_dat;
    logic [CW:0]        w_committed;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_tag_match;
    logic               w_push;
    logic               w_pop;

    // Stale requests still hold a credit until they return, so a matching response always has room.
    assign w_committed = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_credit_ok = (w_committed < (CW+1)'(FIFO_DEPTH));
    assign w_issue     = !reset && !jump_taken && cpu_icache_ready && w_credit_ok;

    assign w_tag_match = cpu_icache_rvalid && (cpu_icache_rtag == r_epoch);
    assign w_push      = w_tag_match && !jump_taken;
    assign w_push_dat  = '{pc: cpu_icache_raddr, instr: cpu_icache_rdata};

    assign ifetch_valid = !reset && !w_fifo_empty;
    assign w_pop        = ifetch_valid && decode_ready && !jump_taken;

    assign cpu_icache_request = w_issue;
    assign cpu_icache_addr    = r_fetch_pc;
    assign cpu_icache_tag     = r_epoch;
    assign ifetch_instr       = w_head.instr;
    assign ifetch_pc          = w_head.pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_ADDR;
            r_epoch    <= '0;
            r_inflight <= '0;
        end else begin
            if (jump_taken) begin
                r_fetch_pc <= jump_target & 32'hFFFF_FFFC;
                r_epoch    <= r_epoch + EPOCH_W'(1);
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(cpu_icache_rvalid);
        end
    end

    cpu_ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_flush    (jump_taken),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_tag_match && w_fifo_full));

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch: icache responder, epoch/PC reference model and delivery scoreboard.
module tb_cpu_ifetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic        cpu_icache_request;
    logic [31:0] cpu_icache_addr;
    logic [8:0]  cpu_icache_tag;
    logic        cpu_icache_ready;
    logic        cpu_icache_rvalid;
    logic [31:0] cpu_icache_rdata;
    logic [31:0] cpu_icache_raddr;
    logic [8:0]  cpu_icache_rtag;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        ifetch_valid;
    logic [31:0] ifetch_instr;
    logic [31:0] ifetch_pc;
    logic        decode_ready;

    cpu_ifetch #(.RESET_ADDR(RST_PC), .FIFO_DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_icache_request (cpu_icache_request),
        .cpu_icache_addr    (cpu_icache_addr),
        .cpu_icache_tag     (cpu_icache_tag),
        .cpu_icache_ready   (cpu_icache_ready),
        .cpu_icache_rvalid  (cpu_icache_rvalid),
        .cpu_icache_rdata   (cpu_icache_rdata),
        .cpu_icache_raddr   (cpu_icache_raddr),
        .cpu_icache_rtag    (cpu_icache_rtag),
        .jump_taken         (jump_taken),
        .jump_target        (jump_target),
        .ifetch_valid       (ifetch_valid),
        .ifetch_instr       (ifetch_instr),
        .ifetch_pc          (ifetch_pc),
        .decode_ready       (decode_ready)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; logic [8:0] tag; int due; } icq_t;

    exp_t        exp_q[$];
    icq_t        icq[$];
    logic [31:0] m_pc;
    logic [8:0]  m_epoch;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // icache: in-order responses, latency drawn per request, memory word i holds i.
    initial begin
        cpu_icache_rvalid = 1'b0;
        cpu_icache_rdata  = '0;
        cpu_icache_raddr  = '0;
        cpu_icache_rtag   = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                icq.delete();
                cpu_icache_rvalid = 1'b0;
            end else if (icq.size() > 0 && icq[0].due <= cyc) begin
                icq_t e;
                e = icq.pop_front();
                cpu_icache_rvalid = 1'b1;
                cpu_icache_raddr  = e.addr;
                cpu_icache_rdata  = e.addr >> 2;
                cpu_icache_rtag   = e.tag;
            end else begin
                cpu_icache_rvalid = 1'b0;
            end
        end
    end

    // Monitor: checks requests against the PC/epoch model and deliveries against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (reset) begin
                chk("rst_request", cpu_icache_request, 0);
                chk("rst_valid", ifetch_valid, 0);
                m_pc    = RST_PC;
                m_epoch = '0;
                exp_q.delete();
                icq.delete();
                last_due = 0;
            end else begin
                if (!cpu_icache_ready || jump_taken) chk("req_gated", cpu_icache_request, 0);
                if (cpu_icache_request) begin
                    int due;
                    chk("req_addr", cpu_icache_addr, m_pc);
                    chk("req_tag", cpu_icache_tag, m_epoch);
                    exp_q.push_back('{pc: m_pc, instr: m_pc >> 2});
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    icq.push_back('{addr: cpu_icache_addr, tag: cpu_icache_tag, due: due});
                    m_pc = m_pc + 32'd4;
                end
                if (jump_taken) begin
                    m_pc    = jump_target & 32'hFFFF_FFFC;
                    m_epoch = m_epoch + 9'd1;
                    exp_q.delete();
                end else if (ifetch_valid && decode_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL deliv_unexpected: got pc %0h, expected no delivery", ifetch_pc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("deliv_pc", ifetch_pc, e.pc);
                        chk("deliv_instr", ifetch_instr, e.instr);
                    end
                end
            end
        end
    end

    // Caller is 2 time units after a falling edge; returns at the next falling edge.
    task automatic wait_req_chk(input string nm, input logic [31:0] addr, input logic [8:0] tag);
        bit found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (k > 0) begin @(negedge clock); #2; end
            if (cpu_icache_request) begin
                found = 1;
                chk({nm, "_addr"}, cpu_icache_addr, addr);
                chk({nm, "_tag"}, cpu_icache_tag, tag);
            end
        end
        if (!found) chk({nm, "_timeout"}, 0, 1);
        @(negedge clock);
    endtask

    task automatic wait_del_chk(input string nm, input logic [31:0] pc);
        bit found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (k > 0) begin @(negedge clock); #2; end
            if (ifetch_valid && decode_ready) begin
                found = 1;
                chk(nm, ifetch_pc, pc);
            end
        end
        if (!found) chk({nm, "_timeout"}, 0, 1);
        @(negedge clock);
    endtask

    initial begin
        int first_v, nv, nr, on_r, off_r, nj;
        reset = 1'b1; cpu_icache_ready = 1'b1; jump_taken = 1'b0;
        jump_target = '0; decode_ready = 1'b1;
        repeat (3) @(negedge clock);

        // Reset release: fill latency and gap-free streaming.
        reset = 1'b0;
        first_v = 0; nv = 0;
        for (int k = 1; k <= 30; k++) begin
            #2;
            if (ifetch_valid && first_v == 0) first_v = k;
            if (k >= 3 && ifetch_valid) nv++;
            @(negedge clock);
        end
        chk("t1_first_valid_cycle", first_v, 3);
        chk("t1_no_gaps", nv, 28);

        // Decode stall from empty: exactly FIFO_DEPTH requests, then in-order drain.
        reset = 1'b1; decode_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0; nr = 0;
        for (int k = 0; k < 10; k++) begin
            #2; if (cpu_icache_request) nr++;
            @(negedge clock);
        end
        chk("t2_req_count", nr, 4);
        #2; chk("t2_req_stalled", cpu_icache_request, 0);
        @(negedge clock);
        decode_ready = 1'b1; nv = 0;
        for (int k = 0; k < 4; k++) begin
            #2; if (ifetch_valid) nv++;
            @(negedge clock);
        end
        chk("t2_drain_valid", nv, 4);
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            #2; if (cpu_icache_request) nr++;
            @(negedge clock);
        end
        chk("t2_resumed", nr > 0, 1);

        // Jump with two requests outstanding.
        lat_min = 2; lat_max = 2;
        repeat (10) @(negedge clock);
        jump_taken = 1'b1; jump_target = 32'h0000_0103;
        @(negedge clock);
        jump_taken = 1'b0;
        #2; chk("t3_flush_empty", ifetch_valid, 0);
        wait_req_chk("t3_first_req", 32'h100, 9'd1);
        #2; wait_del_chk("t3_first_del", 32'h100);

        // Jump coinciding with a matching response and a pop.
        lat_min = 1; lat_max = 1;
        repeat (8) @(negedge clock);
        jump_taken = 1'b1; jump_target = 32'h0000_2000;
        #2; chk("t4_precond", {ifetch_valid, cpu_icache_rvalid}, 2'b11);
        @(negedge clock);
        jump_taken = 1'b0; decode_ready = 1'b0; nr = 0;
        for (int k = 0; k < 10; k++) begin
            #2; if (cpu_icache_request) nr++;
            @(negedge clock);
        end
        chk("t4_credits_restored", nr, 4);
        decode_ready = 1'b1;
        #2; wait_del_chk("t4_first_del", 32'h2000);

        // Epoch wrap: walk epoch to 511 with back-to-back jumps, then jump once more.
        nj = 511 - int'(m_epoch);
        jump_taken = 1'b1; jump_target = 32'h0000_3000;
        repeat (nj) @(negedge clock);
        jump_taken = 1'b0; lat_min = 2; lat_max = 2;
        #2; wait_req_chk("t5_tag511", 32'h3000, 9'd511);
        repeat (2) @(negedge clock);
        jump_taken = 1'b1; jump_target = 32'h0000_0040;
        @(negedge clock);
        jump_taken = 1'b0;
        #2; wait_req_chk("t5_wrap", 32'h40, 9'd0);
        #2; wait_del_chk("t5_first_del", 32'h40);

        // icache ready toggling every cycle.
        lat_min = 1; lat_max = 1;
        repeat (5) @(negedge clock);
        on_r = 0; off_r = 0;
        for (int k = 0; k < 40; k++) begin
            cpu_icache_ready = k[0];
            #2;
            if (cpu_icache_request) begin
                if (cpu_icache_ready) on_r++; else off_r++;
            end
            @(negedge clock);
        end
        chk("t6_req_when_not_ready", off_r, 0);
        chk("t6_req_when_ready", on_r, 20);

        // Randomized traffic with one mid-run reset.
        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            reset            = (k >= 1500 && k < 1502);
            cpu_icache_ready = ($urandom % 4) != 0;
            decode_ready     = ($urandom % 3) != 0;
            jump_taken       = ($urandom % 40) == 0;
            jump_target      = $urandom;
            @(negedge clock);
        end

        reset = 1'b0; jump_taken = 1'b0; cpu_icache_ready = 1'b0; decode_ready = 1'b1;
        repeat (20) @(negedge clock);
        #4;
        chk("drain_scoreboard_empty", exp_q.size(), 0);
        chk("drain_valid_low", ifetch_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
